dospi_tx: RTL and testbench



---
 rtl/dospi_tx.sv | 161 ++++++++++++++++
 tb/tb_dospi_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dospi_tx.sv
// dospi_tx: APA102-style frame serializer. Accepts one 32-bit start, LED or
// end frame per start request. It shifts the frame out MSB-first in SPI mode 0
// at a divided SCK rate. It counts the LED frames sent since the last start frame.
module dospi_tx #(
    parameter int         CLK_DIV           = 4,
    parameter logic [4:0] GLOBAL_BRIGHTNESS = 5'h1f
) (
    input  logic       dospi_tx_clk,
    input  logic       dospi_tx_reset,
    input  logic       dospi_tx_start,
    input  logic [1:0] type_input,
    input  logic [7:0] blue_input,
    input  logic [7:0] green_input,
    input  logic [7:0] red_input,
    output logic       dospi_tx_busy,
    output logic       mosi,
    output logic       sck,
    output logic [7:0] led_count
);

    // Last divider value of a phase; every phase lasts CLK_DIV system clocks.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        TAIL
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_q, div_d;
    logic [1:0]  type_q, type_d;
    logic        mosi_q, mosi_d;
    logic        sck_q, sck_d;
    logic        busy_q, busy_d;
    logic [7:0]  led_count_q, led_count_d;

    logic [31:0] frame_word;
    logic        accept;
    logic        phase_done;

    // Assemble the frame word from the current request inputs.
    always_comb begin
        frame_word = 32'hFFFF_FFFF;
        case (type_input)
            2'd0:    frame_word = 32'h0000_0000;
            2'd1:    frame_word = {3'b111, GLOBAL_BRIGHTNESS, blue_input, green_input, red_input};
            default: frame_word = 32'hFFFF_FFFF;
        endcase
    end

    assign accept     = (state_q == IDLE) && dospi_tx_start && !start_q;
    assign phase_done = (div_q == DIV_LAST);

    // Next-state logic: start-edge capture, phase sequencing, shifting, counting.
    always_comb begin
        state_d     = state_q;
        start_d     = dospi_tx_start;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        type_d      = type_q;
        mosi_d      = mosi_q;
        sck_d       = sck_q;
        busy_d      = busy_q;
        led_count_d = led_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = frame_word;
                    mosi_d    = frame_word[31];
                    busy_d    = 1'b1;
                    bit_cnt_d = 5'd31;
                    div_d     = 8'd0;
                    type_d    = type_input;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (phase_done) begin
                    sck_d   = 1'b1;
                    div_d   = 8'd0;
                    state_d = HIGH;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    sck_d = 1'b0;
                    div_d = 8'd0;
                    if (bit_cnt_q != 5'd0) begin
                        // Next bit goes out on the falling edge, ahead of its rise.
                        shift_d   = shift_q << 1;
                        mosi_d    = shift_q[30];
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        state_d   = LOW;
                    end else begin
                        state_d = TAIL;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            TAIL: begin
                if (phase_done) begin
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    div_d   = 8'd0;
                    state_d = IDLE;
                    case (type_q)
                        2'd0:    led_count_d = 8'd0;
                        2'd1:    led_count_d = led_count_q + 8'd1;
                        default: led_count_d = led_count_q;
                    endcase
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge dospi_tx_clk or posedge dospi_tx_reset) begin
        if (dospi_tx_reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            shift_q     <= 32'd0;
            bit_cnt_q   <= 5'd0;
            div_q       <= 8'd0;
            type_q      <= 2'd0;
            mosi_q      <= 1'b0;
            sck_q       <= 1'b0;
            busy_q      <= 1'b0;
            led_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            type_q      <= type_d;
            mosi_q      <= mosi_d;
            sck_q       <= sck_d;
            busy_q      <= busy_d;
            led_count_q <= led_count_d;
        end
    end

    assign dospi_tx_busy = busy_q;
    assign mosi          = mosi_q;
    assign sck           = sck_q;
    assign led_count     = led_count_q;

endmodule

// File: tb/tb_dospi_tx.sv
// Self-checking bench for dospi_tx: table of fixed frames, randomized frames
// against a frame-level reference model, plus reset, handshake and wrap sequences.
module tb_dospi_tx;

    localparam int D = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] type_in;
    logic [7:0] blue, green, red;
    logic       busy, mosi, sck;
    logic [7:0] led_count;

    dospi_tx #(.CLK_DIV(D), .GLOBAL_BRIGHTNESS(5'h1f)) u_dut (
        .dospi_tx_clk   (clk),
        .dospi_tx_reset (rst),
        .dospi_tx_start (start),
        .type_input     (type_in),
        .blue_input     (blue),
        .green_input    (green),
        .red_input      (red),
        .dospi_tx_busy  (busy),
        .mosi           (mosi),
        .sck            (sck),
        .led_count      (led_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wand-side receiver: shift in mosi on every sck rise.
    logic [31:0] cap = 32'd0;
    int          rise_cnt = 0;
    always @(posedge sck) begin
        cap      = {cap[30:0], mosi};
        rise_cnt = rise_cnt + 1;
    end

    // Total clock edges seen with busy high.
    int busy_cnt = 0;
    always @(posedge clk) if (busy) busy_cnt = busy_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model at frame level.
    function automatic logic [31:0] model_word(input logic [1:0] t, input logic [7:0] b,
                                               input logic [7:0] g, input logic [7:0] r);
        if (t == 2'd0) return 32'h0000_0000;
        if (t == 2'd1) return {8'hFF, b, g, r};   // 3'b111 with brightness 5'h1f
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [7:0] model_count(input logic [1:0] t, input logic [7:0] cur);
        if (t == 2'd0) return 8'd0;
        if (t == 2'd1) return 8'((int'(cur) + 1) % 256);
        return cur;
    endfunction

    task automatic run_frame(input logic [1:0] t, input logic [7:0] b, input logic [7:0] g,
                             input logic [7:0] r, input logic [31:0] exp_word,
                             input logic [7:0] exp_cnt, input bit mid);
        int  rise0, busy0, guard;
        bit  seen;
        @(negedge clk);
        type_in = t; blue = b; green = g; red = r;
        rise0 = rise_cnt; busy0 = busy_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_latency", {31'd0, busy}, 32'd1);
        chk("mosi_msb", {31'd0, mosi}, {31'd0, exp_word[31]});
        chk("sck_low_at_accept", {31'd0, sck}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after acceptance; the latched word must not change.
        type_in = 2'($urandom); blue = 8'($urandom); green = 8'($urandom); red = 8'($urandom);
        if (mid) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            repeat (2) @(negedge clk);
            start = 1'b0;
        end
        guard = 0;
        while (busy === 1'b1 && guard < 65 * D + 10) begin
            @(negedge clk);
            guard++;
        end
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("bits", cap, exp_word);
        chk("sck_rises", 32'(rise_cnt - rise0), 32'd32);
        chk("busy_len", 32'(busy_cnt - busy0), 32'(65 * D));
        chk("led_count", {24'd0, led_count}, {24'd0, exp_cnt});
        chk("mosi_idle", {31'd0, mosi}, 32'd0);
        chk("sck_idle", {31'd0, sck}, 32'd0);
        seen = 1'b0;
        repeat (2 * D + 4) begin
            @(negedge clk);
            if (busy !== 1'b0) seen = 1'b1;
        end
        chk("no_queued_frame", {31'd0, seen}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  typ;
        logic [7:0]  b, g, r;
        logic [31:0] exp_word;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] mcnt;
    logic [1:0] t;
    logic [7:0] b, g, r;

    initial begin
        vecs[0] = '{2'd0, 8'h11, 8'h22, 8'h33, 32'h0000_0000, 8'd0};
        vecs[1] = '{2'd1, 8'h80, 8'h02, 8'h80, 32'hFF80_0280, 8'd1};
        vecs[2] = '{2'd3, 8'h00, 8'h00, 8'h00, 32'hFFFF_FFFF, 8'd1};
        vecs[3] = '{2'd2, 8'h12, 8'h34, 8'h56, 32'hFFFF_FFFF, 8'd1};
        vecs[4] = '{2'd1, 8'h01, 8'h02, 8'h03, 32'hFF01_0203, 8'd2};
        vecs[5] = '{2'd1, 8'h00, 8'h00, 8'h00, 32'hFF00_0000, 8'd3};
        vecs[6] = '{2'd0, 8'hAA, 8'hBB, 8'hCC, 32'h0000_0000, 8'd0};

        rst = 1'b1; start = 1'b0; type_in = 2'd0; blue = 8'd0; green = 8'd0; red = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_sck", {31'd0, sck}, 32'd0);
        chk("rst_led_count", {24'd0, led_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fixed frames.
        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].typ, vecs[i].b, vecs[i].g, vecs[i].r,
                      vecs[i].exp_word, vecs[i].exp_cnt, 1'b0);
        mcnt = 8'd0;

        // Handshake: extra rising edge of start mid-frame must be dropped.
        run_frame(2'd1, 8'h5A, 8'hA5, 8'h3C, model_word(2'd1, 8'h5A, 8'hA5, 8'h3C),
                  model_count(2'd1, mcnt), 1'b1);
        mcnt = model_count(2'd1, mcnt);

        // Randomized frames against the model.
        for (int i = 0; i < 24; i++) begin
            t = 2'($urandom_range(0, 3));
            b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
            run_frame(t, b, g, r, model_word(t, b, g, r), model_count(t, mcnt), 1'b0);
            mcnt = model_count(t, mcnt);
        end

        // Make sure the count is nonzero, then abort a frame with reset.
        run_frame(2'd1, 8'h01, 8'h01, 8'h01, 32'hFF01_0101, model_count(2'd1, mcnt), 1'b0);
        @(negedge clk);
        type_in = 2'd1; blue = 8'hF0; green = 8'h0F; red = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_mosi", {31'd0, mosi}, 32'd0);
        chk("abort_sck", {31'd0, sck}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_led_count", {24'd0, led_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mcnt = 8'd0;
        run_frame(2'd1, 8'hF0, 8'h0F, 8'hC3, 32'hFFF0_0FC3, 8'd1, 1'b0);

        // Wrap: start frame, then 256 LED frames.
        run_frame(2'd0, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 8'd0, 1'b0);
        mcnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
            run_frame(2'd1, b, g, r, model_word(2'd1, b, g, r), model_count(2'd1, mcnt), 1'b0);
            mcnt = model_count(2'd1, mcnt);
        end
        chk("wrap_count", {24'd0, led_count}, 32'd0);
        run_frame(2'd0, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
